// File: rtl/rt_hazard_pkg.sv
// Shared types and default latencies for the decode-stage hazard scoreboard.
package rt_hazard_pkg;

    typedef enum logic [1:0] {
        HZ_ALU      = 2'd0,
        HZ_MEM_READ = 2'd1,
        HZ_V_REDUCE = 2'd2,
        HZ_LINK     = 2'd3
    } hazard_class_e;

    localparam int unsigned DEF_LAT_ALU  = 1;
    localparam int unsigned DEF_LAT_MEM  = 2;
    localparam int unsigned DEF_LAT_VRED = 2;
    localparam int unsigned DEF_LAT_LINK = 4;

    // Scalar result latency of an instruction class
    function automatic int unsigned lat_of(
        input hazard_class_e cls,
        input int unsigned   lat_alu  = DEF_LAT_ALU,
        input int unsigned   lat_mem  = DEF_LAT_MEM,
        input int unsigned   lat_vred = DEF_LAT_VRED,
        input int unsigned   lat_link = DEF_LAT_LINK
    );
        case (cls)
            HZ_MEM_READ: return lat_mem;
            HZ_V_REDUCE: return lat_vred;
            HZ_LINK:     return lat_link;
            default:     return lat_alu;
        endcase
    endfunction

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register countdown counters with a load port, freeze input and
// combinational "still more than one cycle away" lookup per source port.
module sb_counter_bank #(
    parameter int unsigned NUM_REG = 32,
    parameter int unsigned CNT_W   = 3,
    parameter int unsigned NUM_SRC = 2,
    localparam int unsigned AW     = $clog2(NUM_REG)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   load_en,
    input  logic [AW-1:0]          load_addr,
    input  logic [CNT_W-1:0]       load_val,
    input  logic [NUM_SRC*AW-1:0]  src_addr,
    output logic [NUM_SRC-1:0]     busy,
    output logic [NUM_REG-1:0]     pending
);

    logic [CNT_W-1:0] cnt [NUM_REG];

    // Register 0 is never loaded and therefore stays at zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NUM_REG; r++) begin
                cnt[r] <= '0;
            end
        end else begin
            for (int unsigned r = 1; r < NUM_REG; r++) begin
                if (load_en && (load_addr == AW'(r))) begin
                    cnt[r] <= load_val;
                end else if (!hold && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - CNT_W'(1);
                end
            end
        end
    end

    always_comb begin
        busy = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            busy[i] = cnt[src_addr[i*AW +: AW]] > CNT_W'(1);
        end
    end

    always_comb begin
        pending = '0;
        for (int unsigned r = 1; r < NUM_REG; r++) begin
            pending[r] = |cnt[r];
        end
    end

endmodule

// File: rtl/hazard_scoreboard.sv
// Decode-stage stall generator: tracks in-flight scalar/vector writes by
// countdown counters and stalls DE on sources not yet forwardable.
module hazard_scoreboard
    import rt_hazard_pkg::*;
#(
    parameter int unsigned NUM_SREG  = 32,
    parameter int unsigned NUM_VREG  = 16,
    parameter int unsigned NUM_S_SRC = 2,
    parameter int unsigned NUM_V_SRC = 2,
    parameter int unsigned CNT_W     = 3,
    parameter int unsigned LAT_ALU   = DEF_LAT_ALU,
    parameter int unsigned LAT_MEM   = DEF_LAT_MEM,
    parameter int unsigned LAT_VRED  = DEF_LAT_VRED,
    parameter int unsigned LAT_LINK  = DEF_LAT_LINK
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   DE_valid,
    input  logic [NUM_S_SRC*$clog2(NUM_SREG)-1:0]  DE_S_src,
    input  logic [NUM_V_SRC*$clog2(NUM_VREG)-1:0]  DE_V_src,
    input  logic [NUM_S_SRC-1:0]                   DE_S_src_en,
    input  logic [NUM_V_SRC-1:0]                   DE_V_src_en,
    input  logic [$clog2(NUM_SREG)-1:0]            DE_Swb_address,
    input  logic [$clog2(NUM_VREG)-1:0]            DE_Vwb_address,
    input  logic                                   DE_Swb_en,
    input  logic                                   DE_Vwb_en,
    input  hazard_class_e                          DE_class,
    input  logic                                   pipe_hold,
    input  logic                                   flush,
    output logic                                   DE_stall,
    output logic [NUM_SREG-1:0]                    S_pending,
    output logic [NUM_VREG-1:0]                    V_pending
);

    localparam int unsigned SA_W = $clog2(NUM_SREG);
    localparam int unsigned VA_W = $clog2(NUM_VREG);

    logic [NUM_S_SRC-1:0] s_busy;
    logic [NUM_V_SRC-1:0] v_busy;
    logic [NUM_S_SRC-1:0] s_hit;
    logic [NUM_V_SRC-1:0] v_hit;
    logic                 issue;
    logic                 s_load_en;
    logic                 v_load_en;
    logic [CNT_W-1:0]     s_load_val;
    logic [CNT_W-1:0]     v_load_val;

    // Stall OR-tree over enabled, nonzero sources; busy uses pre-issue counts
    always_comb begin
        s_hit = '0;
        v_hit = '0;
        for (int unsigned i = 0; i < NUM_S_SRC; i++) begin
            s_hit[i] = DE_S_src_en[i] && (DE_S_src[i*SA_W +: SA_W] != '0) && s_busy[i];
        end
        for (int unsigned i = 0; i < NUM_V_SRC; i++) begin
            v_hit[i] = DE_V_src_en[i] && (DE_V_src[i*VA_W +: VA_W] != '0) && v_busy[i];
        end
    end

    assign DE_stall = DE_valid && ((|s_hit) || (|v_hit));
    assign issue    = DE_valid && !DE_stall && !pipe_hold && !flush;

    // Vector results only come from memory or the vector ALU; reductions write scalars
    assign s_load_en  = issue && DE_Swb_en && (DE_Swb_address != '0);
    assign v_load_en  = issue && DE_Vwb_en && (DE_Vwb_address != '0) && (DE_class != HZ_V_REDUCE);
    assign s_load_val = CNT_W'(lat_of(DE_class, LAT_ALU, LAT_MEM, LAT_VRED, LAT_LINK));
    assign v_load_val = (DE_class == HZ_MEM_READ) ? CNT_W'(LAT_MEM) : CNT_W'(LAT_ALU);

    sb_counter_bank #(
        .NUM_REG (NUM_SREG),
        .CNT_W   (CNT_W),
        .NUM_SRC (NUM_S_SRC)
    ) u_sbank (
        .clk       (clk),
        .rst       (rst),
        .hold      (pipe_hold),
        .load_en   (s_load_en),
        .load_addr (DE_Swb_address),
        .load_val  (s_load_val),
        .src_addr  (DE_S_src),
        .busy      (s_busy),
        .pending   (S_pending)
    );

    sb_counter_bank #(
        .NUM_REG (NUM_VREG),
        .CNT_W   (CNT_W),
        .NUM_SRC (NUM_V_SRC)
    ) u_vbank (
        .clk       (clk),
        .rst       (rst),
        .hold      (pipe_hold),
        .load_en   (v_load_en),
        .load_addr (DE_Vwb_address),
        .load_val  (v_load_val),
        .src_addr  (DE_V_src),
        .busy      (v_busy),
        .pending   (V_pending)
    );

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Directed bench for hazard_scoreboard: expected stall values queued per cycle.
module tb_hazard_scoreboard;
    import rt_hazard_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          DE_valid;
    logic [9:0]    DE_S_src;
    logic [7:0]    DE_V_src;
    logic [1:0]    DE_S_src_en;
    logic [1:0]    DE_V_src_en;
    logic [4:0]    DE_Swb_address;
    logic [3:0]    DE_Vwb_address;
    logic          DE_Swb_en;
    logic          DE_Vwb_en;
    hazard_class_e DE_class;
    logic          pipe_hold;
    logic          flush;
    logic          DE_stall;
    logic [31:0]   S_pending;
    logic [15:0]   V_pending;

    int unsigned vectors = 0;
    int unsigned fails   = 0;

    bit    exp_q[$];
    string tag_q[$];

    hazard_scoreboard dut (
        .clk            (clk),
        .rst            (rst),
        .DE_valid       (DE_valid),
        .DE_S_src       (DE_S_src),
        .DE_V_src       (DE_V_src),
        .DE_S_src_en    (DE_S_src_en),
        .DE_V_src_en    (DE_V_src_en),
        .DE_Swb_address (DE_Swb_address),
        .DE_Vwb_address (DE_Vwb_address),
        .DE_Swb_en      (DE_Swb_en),
        .DE_Vwb_en      (DE_Vwb_en),
        .DE_class       (DE_class),
        .pipe_hold      (pipe_hold),
        .flush          (flush),
        .DE_stall       (DE_stall),
        .S_pending      (S_pending),
        .V_pending      (V_pending)
    );

    always #5 clk = ~clk;

    task automatic idle();
        DE_valid = 1'b0; DE_S_src = '0; DE_V_src = '0; DE_S_src_en = '0; DE_V_src_en = '0;
        DE_Swb_address = '0; DE_Vwb_address = '0; DE_Swb_en = 1'b0; DE_Vwb_en = 1'b0;
        DE_class = HZ_ALU;
    endtask

    // Scalar writer with no sources
    task automatic s_write(input hazard_class_e cls, input logic [4:0] dst);
        idle();
        DE_valid = 1'b1; DE_class = cls; DE_Swb_address = dst; DE_Swb_en = 1'b1;
    endtask

    // Scalar consumer on port 0 and 1 (port enables given explicitly)
    task automatic s_read(input logic [4:0] a0, input logic [4:0] a1, input logic [1:0] en);
        idle();
        DE_valid = 1'b1; DE_S_src = {a1, a0}; DE_S_src_en = en;
    endtask

    // Push expectation, compare at negedge, advance to just after next posedge
    task automatic cyc(input bit exp_stall, input string tag);
        bit    e;
        string t;
        exp_q.push_back(exp_stall);
        tag_q.push_back(tag);
        @(negedge clk);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        vectors++;
        assert (DE_stall === e) else begin
            fails++;
            $error("FAIL %s: DE_stall=%b expected %b", t, DE_stall, e);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic chk_bit(input logic obs, input logic exp, input string tag);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        idle();
        pipe_hold = 1'b0;
        flush     = 1'b0;
        rst       = 1'b1;
        #12;
        chk_bit(DE_stall, 1'b0, "rst_stall");
        chk_bit(|S_pending, 1'b0, "rst_spend");
        chk_bit(|V_pending, 1'b0, "rst_vpend");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;

        // ALU s5 then immediate consumer: forwardable, no stall
        s_write(HZ_ALU, 5'd5);
        cyc(1'b0, "alu_issue");
        chk_bit(S_pending[5], 1'b1, "alu_spend5");
        s_read(5'd5, 5'd0, 2'b01);
        cyc(1'b0, "alu_fwd");
        idle();
        chk_bit(S_pending[5], 1'b0, "alu_spend5_clear");

        // MEM_READ s7 -> one stall on port 1
        s_write(HZ_MEM_READ, 5'd7);
        cyc(1'b0, "mem_issue");
        s_read(5'd0, 5'd7, 2'b10);
        cyc(1'b1, "mem_stall");
        cyc(1'b0, "mem_go");

        // MEM_READ v3 -> one vector stall
        idle();
        DE_valid = 1'b1; DE_class = HZ_MEM_READ; DE_Vwb_address = 4'd3; DE_Vwb_en = 1'b1;
        cyc(1'b0, "vmem_issue");
        chk_bit(V_pending[3], 1'b1, "vmem_vpend3");
        idle();
        DE_valid = 1'b1; DE_V_src = {4'd0, 4'd3}; DE_V_src_en = 2'b01;
        cyc(1'b1, "vmem_stall");
        cyc(1'b0, "vmem_go");

        // LINK s31 -> three stalls
        s_write(HZ_LINK, 5'd31);
        cyc(1'b0, "link_issue");
        s_read(5'd31, 5'd0, 2'b01);
        cyc(1'b1, "link_stall1");
        cyc(1'b1, "link_stall2");
        cyc(1'b1, "link_stall3");
        cyc(1'b0, "link_go");

        // LINK s31 but consumer only reads s0
        s_write(HZ_LINK, 5'd31);
        cyc(1'b0, "link2_issue");
        s_read(5'd0, 5'd0, 2'b11);
        cyc(1'b0, "s0_nostall");
        idle();
        for (int i = 0; i < 4; i++) cyc(1'b0, "drain");
        chk_bit(S_pending[31], 1'b0, "link_drained");

        // MEM_READ s4 with a two-cycle back-end hold
        s_write(HZ_MEM_READ, 5'd4);
        cyc(1'b0, "hold_issue");
        s_read(5'd4, 5'd0, 2'b01);
        pipe_hold = 1'b1;
        cyc(1'b1, "hold_stall1");
        cyc(1'b1, "hold_stall2");
        chk_bit(S_pending[4], 1'b1, "hold_frozen");
        pipe_hold = 1'b0;
        cyc(1'b1, "hold_stall3");
        cyc(1'b0, "hold_go");

        // Overwrite: MEM s4 then ALU s4
        s_write(HZ_MEM_READ, 5'd4);
        cyc(1'b0, "ow_mem");
        s_write(HZ_ALU, 5'd4);
        cyc(1'b0, "ow_alu");
        s_read(5'd4, 5'd0, 2'b01);
        cyc(1'b0, "ow_consumer");

        // Overwrite: LINK s9 then ALU s9 (reload 1 instead of 3)
        s_write(HZ_LINK, 5'd9);
        cyc(1'b0, "ow_link");
        s_write(HZ_ALU, 5'd9);
        cyc(1'b0, "ow_alu9");
        s_read(5'd9, 5'd0, 2'b01);
        cyc(1'b0, "ow_consumer9");
        idle();
        cyc(1'b0, "ow_idle");

        // Flushed MEM_READ s6 leaves no pending write
        s_write(HZ_MEM_READ, 5'd6);
        flush = 1'b1;
        cyc(1'b0, "flush_mem");
        flush = 1'b0;
        idle();
        chk_bit(S_pending[6], 1'b0, "flush_spend6");

        // V_REDUCE v2 -> s2, vector write enable must be ignored
        idle();
        DE_valid = 1'b1; DE_class = HZ_V_REDUCE; DE_V_src = {4'd0, 4'd2}; DE_V_src_en = 2'b01;
        DE_Swb_address = 5'd2; DE_Swb_en = 1'b1; DE_Vwb_address = 4'd2; DE_Vwb_en = 1'b1;
        cyc(1'b0, "vred_issue");
        chk_bit(|V_pending, 1'b0, "vred_vpend");
        chk_bit(S_pending[2], 1'b1, "vred_spend2");
        s_read(5'd2, 5'd0, 2'b01);
        cyc(1'b1, "vred_stall");
        cyc(1'b0, "vred_go");

        // Reset pulsed mid LINK stall
        s_write(HZ_LINK, 5'd31);
        cyc(1'b0, "rlink_issue");
        s_read(5'd31, 5'd0, 2'b01);
        cyc(1'b1, "rlink_stall");
        chk_bit(DE_stall, 1'b1, "rlink_pre_rst");
        rst = 1'b1;
        #1;
        chk_bit(DE_stall, 1'b0, "rlink_rst_stall");
        chk_bit(|S_pending, 1'b0, "rlink_rst_spend");
        #1;
        rst = 1'b0;
        cyc(1'b0, "rlink_after_rst");
        s_write(HZ_MEM_READ, 5'd7);
        cyc(1'b0, "rmem_issue");
        s_read(5'd7, 5'd0, 2'b01);
        cyc(1'b1, "rmem_stall");
        cyc(1'b0, "rmem_go");
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
